// File: rtl/mmio_timer_pkg.sv
// mmio_timer shared definitions: register map,
// bit positions and default window base.
package mmio_timer_pkg;

  localparam logic [15:0] BASE_DEFAULT = 16'hFF00;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PRESC  = 3'd1;
  localparam logic [2:0] OFF_CMPL   = 3'd2;
  localparam logic [2:0] OFF_CMPH   = 3'd3;
  localparam logic [2:0] OFF_SNAPL  = 3'd4;
  localparam logic [2:0] OFF_SNAPH  = 3'd5;
  localparam logic [2:0] OFF_CMD    = 3'd6;
  localparam logic [2:0] OFF_STATUS = 3'd7;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int CMD_SNAP = 0;
  localparam int CMD_CLR  = 1;

  localparam int ST_MATCH = 0;
  localparam int ST_OVF   = 1;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for mmio_timer: emits one tick
// every PRESC+1 enabled cycles.
module timer_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] presc,
  output logic       tick
);

  logic [7:0] pc;

  assign tick = en & (pc == presc);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      pc <= 8'd0;
    end else if (tick) begin
      pc <= 8'd0;
    end else if (en) begin
      pc <= pc + 8'd1;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped 16-bit timer with prescaler,
// compare match, snapshot and W1C status.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [15:0] BASE = BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [15:0] address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        sel,
  output logic        irq
);

  logic [2:0]  ctrl;
  logic [7:0]  presc;
  logic [7:0]  cmpl;
  logic [7:0]  cmph;
  logic [7:0]  snapl;
  logic [7:0]  snaph;
  logic [1:0]  status;
  logic [15:0] count;

  logic [2:0] off;
  logic       wr;
  logic       wr_ctrl;
  logic       wr_cmd;
  logic       wr_status;
  logic       ctrl_off;
  logic       cmd_clr;
  logic       cmd_snap;
  logic       psc_clr;
  logic       tick;
  logic       tk;
  logic       hit;
  logic       set_match;
  logic       set_ovf;
  logic [1:0] w1c;
  logic [1:0] hw_set;

  assign sel       = (address[15:3] == BASE[15:3]);
  assign off       = address[2:0];
  assign wr        = we & sel;
  assign wr_ctrl   = wr & (off == OFF_CTRL);
  assign wr_cmd    = wr & (off == OFF_CMD);
  assign wr_status = wr & (off == OFF_STATUS);

  assign ctrl_off = wr_ctrl & ~writedata[CTRL_EN];
  assign cmd_clr  = wr_cmd & writedata[CMD_CLR];
  assign cmd_snap = wr_cmd & writedata[CMD_SNAP];
  assign psc_clr  = cmd_clr | ctrl_off;

  timer_prescaler u_psc (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl[CTRL_EN]),
    .clr   (psc_clr),
    .presc (presc),
    .tick  (tick)
  );

  // A clear or a disabling CTRL write freezes count on that edge.
  assign tk        = tick & ~psc_clr;
  assign hit       = (count == {cmph, cmpl});
  assign set_match = tk & hit;
  assign set_ovf   = tk & ~hit & (count == 16'hFFFF);
  assign w1c       = wr_status ? writedata[1:0] : 2'b00;

  always_comb begin
    hw_set           = 2'b00;
    hw_set[ST_MATCH] = set_match;
    hw_set[ST_OVF]   = set_ovf;
  end

  assign irq = ctrl[CTRL_IRQ_EN] & (|status);

  always_comb begin
    readdata = 8'h00;
    unique case (1'b1)
      sel && off == OFF_CTRL:   readdata = {5'b0, ctrl};
      sel && off == OFF_PRESC:  readdata = presc;
      sel && off == OFF_CMPL:   readdata = cmpl;
      sel && off == OFF_CMPH:   readdata = cmph;
      sel && off == OFF_SNAPL:  readdata = snapl;
      sel && off == OFF_SNAPH:  readdata = snaph;
      sel && off == OFF_STATUS: readdata = {6'b0, status};
      default:                  readdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl   <= 3'd0;
      presc  <= 8'd0;
      cmpl   <= 8'd0;
      cmph   <= 8'd0;
      snapl  <= 8'd0;
      snaph  <= 8'd0;
      status <= 2'd0;
      count  <= 16'd0;
    end else begin
      if (wr_ctrl) begin
        ctrl <= writedata[2:0];
      end else if (set_match && !ctrl[CTRL_AUTO]) begin
        ctrl[CTRL_EN] <= 1'b0;
      end
      if (wr && off == OFF_PRESC) presc <= writedata;
      if (wr && off == OFF_CMPL)  cmpl  <= writedata;
      if (wr && off == OFF_CMPH)  cmph  <= writedata;
      if (cmd_snap) begin
        snapl <= count[7:0];
        snaph <= count[15:8];
      end
      if (cmd_clr) begin
        count <= 16'd0;
      end else if (tk) begin
        if (!hit) begin
          count <= count + 16'd1;
        end else if (ctrl[CTRL_AUTO]) begin
          count <= 16'd0;
        end
      end
      status <= (status & ~w1c) | hw_set;
    end
  end

endmodule

// File: doc/mmio_timer.md
MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 Parameter BASE, default 16'hFF00, SHALL give the 8-byte-aligned base address of the register window (BASE..BASE+7).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 we  input  1  bus write strobe from the processor.
REQ-005 address  input  16  bus byte address.
REQ-006 writedata  input  8  bus write data.
REQ-007 readdata  output  8  combinational read data: the addressed register when sel=1, else 8'h00.
REQ-008 sel  output  1  combinational; high when address[15:3]==BASE[15:3]. Top-level uses it to mux readdata and gate memory we.
REQ-009 irq  output  1  registered-source interrupt: CTRL.IRQ_EN & (STATUS.MATCH | STATUS.OVF).

Function
REQ-010 Register offset is address[2:0]: 0 CTRL, 1 PRESC, 2 CMPL, 3 CMPH, 4 SNAPL, 5 SNAPH, 6 CMD, 7 STATUS.
REQ-011 CTRL SHALL be R/W: bit0 EN, bit1 AUTO (periodic), bit2 IRQ_EN; bits 7:3 SHALL read 0 and ignore writes.
REQ-012 PRESC, CMPL and CMPH SHALL be R/W 8-bit registers. CMP = {CMPH,CMPL}.
REQ-013 SNAPL/SNAPH SHALL be read-only; writes ignored.
REQ-014 CMD SHALL be write-only and read 0: bit0 SNAP copies the 16-bit count into SNAP at that edge; bit1 CLR zeroes count and prescaler.
REQ-015 STATUS SHALL be bit0 MATCH, bit1 OVF. Writing 1 clears a bit, writing 0 has no effect, other bits read 0.
REQ-016 A register write SHALL occur only on an edge where we=1 and sel=1. Out-of-window accesses SHALL change no state.
REQ-017 The 8-bit prescaler counter pc SHALL run only while EN=1. tick = EN & (pc==PRESC). On tick pc returns to 0, otherwise pc increments. PRESC=0 SHALL therefore tick every cycle.
REQ-018 On a tick edge with count==CMP, the block SHALL set MATCH. If AUTO=1, count returns to 0. If AUTO=0, count holds and EN clears (one-shot).
REQ-019 On a tick edge with count!=CMP, count SHALL increment modulo 2^16. On the wrap 16'hFFFF->0, OVF SHALL be set.
REQ-020 A write of CTRL with EN=0 SHALL reset pc to 0 and hold count.
REQ-021 Simultaneous hardware set and W1C of the same STATUS bit: set SHALL win.
REQ-022 CMD.CLR coincident with a tick: CLR SHALL win; no MATCH or OVF is set that edge.
REQ-023 CMD.SNAP coincident with a count update: SNAP SHALL capture the pre-edge count value.
REQ-024 A CTRL write coincident with a one-shot EN clear: the written value SHALL win.
REQ-025 Each MMIO write SHALL take effect at the edge where it is presented. Its effect is readable combinationally in the next cycle.

Reset
REQ-026 On reset=1 at an edge, the block SHALL set CTRL, PRESC, CMPL, CMPH, SNAPL, SNAPH, STATUS, pc and count to 0. irq SHALL then be 0 from the following cycle.
REQ-027 Reset SHALL take priority over every bus write and tick in the same edge, including during an active count.

Structure
REQ-028 A shared package SHALL hold: register offset constants, CTRL/CMD/STATUS bit-position constants, and the BASE default.
REQ-029 The prescaler SHALL be one sub-module, timer_prescaler. Inputs: clk, reset, en, clr, presc[7:0]. Output: tick. Count, compare and register logic SHALL stay in mmio_timer.

Verification
REQ-030 PRESC=0, CMP=3, CTRL=0x03: count SHALL follow 1,2,3,0 with period 4 cycles. MATCH SHALL set on the edge count goes 3->0.
REQ-031 PRESC=2, CMP=16'hFFFF, EN=1: count SHALL increment once every 3 cycles. After 9 cycles, CMD SNAP then reading SNAPL SHALL return 3.
REQ-032 One-shot, PRESC=0, CMP=5, CTRL=0x05: MATCH SHALL set after 6 ticks, CTRL.EN reads 0, count holds 5 and irq=1. Writing STATUS=0x01 SHALL drop irq the next cycle.
REQ-033 Run with CMP=16'hFFFF to count 10, then write CMPL=5/CMPH=0: count SHALL run to 16'hFFFF and wrap to 0 with OVF=1. MATCH SHALL set later, at count 5.
REQ-034 W1C of MATCH on the same edge MATCH is set: MATCH SHALL read 1 afterwards.
REQ-035 Write to BASE-1 and BASE+8 with data 0xFF: sel SHALL be 0, readdata 0, and all registers unchanged. Reset asserted mid-count SHALL return all registers to 0.
